// File: rtl/audio_vis_pkg.sv
`default_nettype none
// ============================================================================
// audio_vis_pkg: shared writer-FSM / bank-status encodings and frame defaults.
// Revision 1.0
// ============================================================================
package audio_vis_pkg;

    localparam int unsigned FRAME_LEN_DEFAULT = 256;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FILL  = 2'd1,
        WR_STALL = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_status_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mono_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// mono_frame_scheduler_if: sample input, frame presentation and status bundle.
// Revision 1.0
// ============================================================================
interface mono_frame_scheduler_if import audio_vis_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(FRAME_LEN_DEFAULT)
);
    logic                  enable;
    logic                  mono_sample_valid;
    logic [DATA_WIDTH-1:0] mono_sample;
    logic                  frame_ready;
    logic                  frame_bank;
    logic                  frame_ack;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  overflow;
    logic                  overflow_clr;
    logic [15:0]           dropped_count;

    modport master (
        output enable, mono_sample_valid, mono_sample, frame_ack, rd_addr, overflow_clr,
        input  frame_ready, frame_bank, rd_data, overflow, dropped_count
    );

    modport slave (
        input  enable, mono_sample_valid, mono_sample, frame_ack, rd_addr, overflow_clr,
        output frame_ready, frame_bank, rd_data, overflow, dropped_count
    );
endinterface
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// ============================================================================
// frame_bank_ram: simple dual-port RAM, address {bank, index}, registered read.
// Revision 1.0
// ============================================================================
module frame_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array carries no reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/mono_frame_scheduler.sv
`default_nettype none
// ============================================================================
// mono_frame_scheduler: ping-pong capture of mono samples into two frame banks.
// Revision 1.0
// ============================================================================
module mono_frame_scheduler import audio_vis_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                    S_AXIS_ACLK,
    input  logic                    S_AXIS_ARESETN,
    mono_frame_scheduler_if.slave   bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    wr_state_e             fsm_q, fsm_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    bank_status_e          bank_st_q [2];
    bank_status_e          bank_st_d [2];
    logic                  frame_ready_q, frame_ready_d;
    logic                  frame_bank_q, frame_bank_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           dropped_q, dropped_d;

    logic                  other_bank;
    logic                  release_ack;
    logic                  drop;
    logic                  ram_we;

    assign other_bank  = ~wr_bank_q;
    assign release_ack = bus.frame_ack && frame_ready_q;

    always_comb begin
        fsm_d         = fsm_q;
        wr_bank_d     = wr_bank_q;
        wr_idx_d      = wr_idx_q;
        bank_st_d     = bank_st_q;
        frame_ready_d = frame_ready_q;
        frame_bank_d  = frame_bank_q;
        overflow_d    = overflow_q;
        dropped_d     = dropped_q;
        drop          = 1'b0;
        ram_we        = 1'b0;

        // Only one bank can be FULL and unpresented at a time; the one after
        // the last presented bank is tried first so fill order is preserved.
        if (release_ack) begin
            bank_st_d[frame_bank_q] = BANK_EMPTY;
            frame_ready_d           = 1'b0;
        end else if (!frame_ready_q) begin
            if (bank_st_q[~frame_bank_q] == BANK_FULL) begin
                frame_ready_d = 1'b1;
                frame_bank_d  = ~frame_bank_q;
            end else if (bank_st_q[frame_bank_q] == BANK_FULL) begin
                frame_ready_d = 1'b1;
            end
        end

        // Writer decisions see a bank released on this same edge as EMPTY.
        unique case (fsm_q)
            WR_IDLE: begin
                if (bus.enable) begin
                    wr_idx_d = '0;
                    if (bank_st_d[wr_bank_q] == BANK_EMPTY) begin
                        fsm_d                = WR_FILL;
                        bank_st_d[wr_bank_q] = BANK_FILLING;
                    end else if (bank_st_d[other_bank] == BANK_EMPTY) begin
                        fsm_d                 = WR_FILL;
                        wr_bank_d             = other_bank;
                        bank_st_d[other_bank] = BANK_FILLING;
                    end else begin
                        fsm_d = WR_STALL;
                    end
                end
            end
            WR_FILL: begin
                if (!bus.enable) begin
                    fsm_d                = WR_IDLE;
                    wr_idx_d             = '0;
                    bank_st_d[wr_bank_q] = BANK_EMPTY;
                end else if (bus.mono_sample_valid) begin
                    ram_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d             = '0;
                        bank_st_d[wr_bank_q] = BANK_FULL;
                        if (bank_st_d[other_bank] == BANK_EMPTY) begin
                            wr_bank_d             = other_bank;
                            bank_st_d[other_bank] = BANK_FILLING;
                        end else begin
                            fsm_d = WR_STALL;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            WR_STALL: begin
                drop = bus.mono_sample_valid;
                if (!bus.enable) begin
                    fsm_d = WR_IDLE;
                end else if (bank_st_d[other_bank] == BANK_EMPTY) begin
                    fsm_d                 = WR_FILL;
                    wr_bank_d             = other_bank;
                    wr_idx_d              = '0;
                    bank_st_d[other_bank] = BANK_FILLING;
                end else if (bank_st_d[wr_bank_q] == BANK_EMPTY) begin
                    fsm_d                = WR_FILL;
                    wr_idx_d             = '0;
                    bank_st_d[wr_bank_q] = BANK_FILLING;
                end
            end
            default: fsm_d = WR_IDLE;
        endcase

        // A drop coinciding with a clear survives as a single counted drop.
        if (bus.overflow_clr) begin
            overflow_d = drop;
            dropped_d  = {15'd0, drop};
        end else if (drop) begin
            overflow_d = 1'b1;
            dropped_d  = sat_inc16(dropped_q);
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            fsm_q         <= WR_IDLE;
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            bank_st_q[0]  <= BANK_EMPTY;
            bank_st_q[1]  <= BANK_EMPTY;
            frame_ready_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            overflow_q    <= 1'b0;
            dropped_q     <= 16'd0;
        end else begin
            fsm_q         <= fsm_d;
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            bank_st_q     <= bank_st_d;
            frame_ready_q <= frame_ready_d;
            frame_bank_q  <= frame_bank_d;
            overflow_q    <= overflow_d;
            dropped_q     <= dropped_d;
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (S_AXIS_ACLK),
        .rst_n   (S_AXIS_ARESETN),
        .wr_en   (ram_we),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_data (bus.mono_sample),
        .rd_addr ({frame_bank_q, bus.rd_addr}),
        .rd_data (bus.rd_data)
    );

    assign bus.frame_ready   = frame_ready_q;
    assign bus.frame_bank    = frame_bank_q;
    assign bus.overflow      = overflow_q;
    assign bus.dropped_count = dropped_q;
endmodule
`default_nettype wire

// File: tb/tb_mono_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mono_frame_scheduler: directed stimulus checked against a queue-based model.
// Revision 1.0
// ============================================================================
module tb_mono_frame_scheduler;
    localparam int FL = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mono_frame_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    mono_frame_scheduler #(
        .DATA_WIDTH (32),
        .FRAME_LEN  (FL),
        .ADDR_WIDTH (3)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 filling, 2 stalled; complete frames queue in fill order.
    int          m_mode, m_wr, m_idx, m_bank, m_cnt;
    int          m_full[$];
    bit          m_ready, m_ov, m_rd_valid;
    logic [31:0] m_mem [2][FL];
    logic [31:0] m_rd;

    function automatic bit m_free(input int b);
        if (m_mode == 1 && b == m_wr) return 1'b0;
        foreach (m_full[i]) if (m_full[i] == b) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_step();
        bit drop;
        drop = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_wr = 0; m_idx = 0; m_bank = 0; m_cnt = 0;
            m_full.delete(); m_ready = 0; m_ov = 0; m_rd_valid = 0; m_rd = '0;
            return;
        end
        m_rd_valid = m_ready;
        if (m_ready) m_rd = m_mem[m_bank][bus.rd_addr];
        if (m_ready && bus.frame_ack) begin
            m_ready = 0;
            void'(m_full.pop_front());
        end else if (!m_ready && m_full.size() > 0) begin
            m_ready = 1;
            m_bank  = m_full[0];
        end
        case (m_mode)
            0: if (bus.enable) begin
                m_idx = 0;
                if (m_free(m_wr)) m_mode = 1;
                else if (m_free(1 - m_wr)) begin m_wr = 1 - m_wr; m_mode = 1; end
                else m_mode = 2;
            end
            1: if (!bus.enable) begin
                m_mode = 0; m_idx = 0;
            end else if (bus.mono_sample_valid) begin
                m_mem[m_wr][m_idx] = bus.mono_sample;
                m_idx++;
                if (m_idx == FL) begin
                    m_idx = 0;
                    m_full.push_back(m_wr);
                    if (m_free(1 - m_wr)) m_wr = 1 - m_wr;
                    else m_mode = 2;
                end
            end
            default: begin
                drop = bus.mono_sample_valid;
                if (!bus.enable) m_mode = 0;
                else if (m_free(1 - m_wr)) begin m_wr = 1 - m_wr; m_mode = 1; m_idx = 0; end
                else if (m_free(m_wr)) begin m_mode = 1; m_idx = 0; end
            end
        endcase
        if (bus.overflow_clr) begin
            m_ov = drop; m_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ov = 1;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end
    endtask

    always @(posedge clk) begin
        m_step();
        #1;
        chk("m_frame_ready", 32'(bus.frame_ready), 32'(m_ready));
        if (m_ready || !rst_n) chk("m_frame_bank", 32'(bus.frame_bank), 32'(m_bank));
        chk("m_overflow", 32'(bus.overflow), 32'(m_ov));
        chk("m_dropped", 32'(bus.dropped_count), 32'(m_cnt));
        if (!rst_n) chk("m_rd_data_rst", bus.rd_data, 32'd0);
        else if (m_rd_valid) chk("m_rd_data", bus.rd_data, m_rd);
    end

    task automatic cyc(input bit en, input bit v, input logic [31:0] s,
                       input bit ack, input bit clr, input int addr);
        bus.enable            = en;
        bus.mono_sample_valid = v;
        bus.mono_sample       = s;
        bus.frame_ack         = ack;
        bus.overflow_clr      = clr;
        bus.rd_addr           = 3'(addr);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_ready", 32'(bus.frame_ready), 0);
        chk("rst_bank", 32'(bus.frame_bank), 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_dropped", 32'(bus.dropped_count), 0);
        rst_n = 1'b1;

        // Fill bank 0 with 1..8
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < FL; i++) cyc(1, 1, 32'(i + 1), 0, 0, 0);
        chk("fill_ready_latency", 32'(bus.frame_ready), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("fill_ready", 32'(bus.frame_ready), 1);
        chk("fill_bank", 32'(bus.frame_bank), 0);
        for (int i = 0; i < FL; i++) begin
            cyc(1, 0, 0, 0, 0, i);
            chk("fill_rd", bus.rd_data, 32'(i + 1));
        end

        // Second frame 9..16 into bank 1 without ack: writer stalls
        for (int i = 0; i < FL; i++) cyc(1, 1, 32'(i + 9), 0, 0, 0);
        chk("pp_hold_ready", 32'(bus.frame_ready), 1);
        chk("pp_hold_bank", 32'(bus.frame_bank), 0);

        // Overflow while both banks are full
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h77, 0, 0, 0);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_count3", 32'(bus.dropped_count), 3);
        cyc(1, 1, 32'h78, 0, 1, 0);
        chk("ovf_clr_drop_flag", 32'(bus.overflow), 1);
        chk("ovf_clr_drop_count", 32'(bus.dropped_count), 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("ovf_clr_flag", 32'(bus.overflow), 0);
        chk("ovf_clr_count", 32'(bus.dropped_count), 0);

        // Release bank 0: one low cycle, then bank 1 presented
        cyc(1, 0, 0, 1, 0, 0);
        chk("pp_ack_low", 32'(bus.frame_ready), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pp_ready", 32'(bus.frame_ready), 1);
        chk("pp_bank", 32'(bus.frame_bank), 1);
        for (int i = 0; i < FL; i++) begin
            cyc(1, 0, 0, 0, 0, i);
            chk("pp_rd", bus.rd_data, 32'(i + 9));
        end
        cyc(1, 0, 0, 1, 0, 0);
        chk("ack_release", 32'(bus.frame_ready), 0);
        cyc(1, 0, 0, 1, 0, 0);
        chk("ack_ignored", 32'(bus.frame_ready), 0);

        // Abort a partial frame, strobe while idle, then refill bank 0
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'(50 + i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'd99, 0, 0, 0);
        chk("idle_no_drop", 32'(bus.dropped_count), 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < FL; i++) cyc(1, 1, 32'(101 + i), 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("abort_ready", 32'(bus.frame_ready), 1);
        chk("abort_bank", 32'(bus.frame_bank), 0);
        for (int i = 0; i < FL; i++) begin
            cyc(1, 0, 0, 0, 0, i);
            chk("abort_rd", bus.rd_data, 32'(101 + i));
        end

        // Asynchronous reset mid-fill with a frame presented
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'(201 + i), 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 5);
        chk("pre_rst_rd", bus.rd_data, 32'd106);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_ready", 32'(bus.frame_ready), 0);
        chk("async_bank", 32'(bus.frame_bank), 0);
        chk("async_rd_data", bus.rd_data, 0);
        chk("async_overflow", 32'(bus.overflow), 0);
        chk("async_dropped", 32'(bus.dropped_count), 0);
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Fresh fill after reset lands in bank 0
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < FL; i++) cyc(1, 1, 32'(301 + i), 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("post_rst_ready", 32'(bus.frame_ready), 1);
        chk("post_rst_bank", 32'(bus.frame_bank), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("post_rst_rd0", bus.rd_data, 32'd301);
        cyc(1, 0, 0, 0, 0, 7);
        chk("post_rst_rd7", bus.rd_data, 32'd308);
        cyc(1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mono_frame_scheduler.md
MONO_FRAME_SCHEDULER -- requirements
Module: mono_frame_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, mono sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 256, samples per frame; power of two, minimum 4.
REQ-003 SHALL have parameter ADDR_WIDTH, default log2(FRAME_LEN), frame index width.
REQ-004 SHALL have port S_AXIS_ACLK  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXIS_ARESETN  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  capture enable.
REQ-007 SHALL have port mono_sample_valid  input  1  one-cycle sample strobe from the stereo-to-mono converter.
REQ-008 SHALL have port mono_sample  input  DATA_WIDTH  mono sample; valid when strobe high.
REQ-009 SHALL have port frame_ready  output  1  the presented bank holds a complete frame.
REQ-010 SHALL have port frame_bank  output  1  index of the presented bank.
REQ-011 SHALL have port frame_ack  input  1  consumer done with the presented bank.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  consumer read index into the presented bank.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port overflow  output  1  sticky; a sample was dropped.
REQ-015 SHALL have port overflow_clr  input  1  clears overflow.
REQ-016 SHALL have port dropped_count  output  16  saturating count of dropped samples.

Function
REQ-017 SHALL hold two banks of FRAME_LEN words; each bank status is EMPTY, FILLING or FULL.
REQ-018 Writer FSM SHALL have states IDLE, FILL and STALL.
REQ-019 In IDLE, strobes SHALL be ignored and not counted; enable high SHALL move to FILL, using the current write bank at index 0.
REQ-020 In FILL, each strobe SHALL write mono_sample to the write bank at the write index and then increment the index.
REQ-021 The strobe at index FRAME_LEN-1 SHALL mark the bank FULL and reset the index to 0.
REQ-022 On that same edge, the write bank SHALL switch to the other bank if the other bank is EMPTY; otherwise the FSM SHALL enter STALL.
REQ-023 In STALL, each strobe SHALL be dropped, set overflow and increment dropped_count, saturating at 0xFFFF.
REQ-024 When a bank is released in STALL, the FSM SHALL enter FILL on that bank at index 0.
REQ-025 A strobe on the release cycle in STALL SHALL still be dropped and counted.
REQ-026 enable low in FILL SHALL discard the partial frame, return the index to 0, leave the bank EMPTY and enter IDLE.
REQ-027 enable low in STALL SHALL enter IDLE; FULL banks SHALL stay FULL.
REQ-028 Presentation: frame_ready SHALL rise the cycle after a bank becomes FULL if no bank is presented, with frame_bank set to that bank.
REQ-029 frame_ready and frame_bank SHALL be held stable until frame_ack.
REQ-030 frame_ack while frame_ready is high SHALL set the bank EMPTY and deassert frame_ready on the next edge.
REQ-031 After a release, if the other bank is FULL, frame_ready SHALL reassert one cycle later with frame_bank toggled.
REQ-032 Banks SHALL be presented strictly in fill order.
REQ-033 frame_ack while frame_ready is low SHALL be ignored.
REQ-034 rd_data SHALL equal the contents of bank frame_bank at rd_addr, one cycle after rd_addr is applied.
REQ-035 rd_data is meaningful only while frame_ready is high; the writer never writes the presented bank.
REQ-036 overflow_clr SHALL clear overflow and dropped_count; a simultaneous drop SHALL win, leaving overflow=1 and dropped_count=1.
REQ-037 No arithmetic SHALL be applied to samples; they are stored bit-exact.

Reset
REQ-038 Asserting S_AXIS_ARESETN low SHALL immediately force: FSM IDLE, write bank 0, index 0, both banks EMPTY, frame_ready=0, frame_bank=0, rd_data=0, overflow=0, dropped_count=0.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset mid-frame SHALL discard all frames, including any presented frame, without requiring frame_ack.

Structure
REQ-041 FSM state encoding, bank status encoding and the default FRAME_LEN SHALL live in shared package audio_vis_pkg.
REQ-042 Storage SHALL be sub-module frame_bank_ram: 2*FRAME_LEN x DATA_WIDTH simple dual-port RAM, one write port, one synchronous read port, address {bank, index}.

Verification (FRAME_LEN=8)
REQ-043 Fill: enable=1, 8 strobes of 1..8 -> frame_ready=1, frame_bank=0 one cycle after the 8th strobe; reading rd_addr 0..7 returns 1..8, each one cycle after its address.
REQ-044 Ping-pong: continue with 8 strobes of 9..16 without ack -> bank 1 FULL and FSM in STALL; ack -> frame_bank toggles to 1 after one low cycle of frame_ready; reads return 9..16.
REQ-045 Overflow: both banks FULL, 3 strobes -> overflow=1, dropped_count=3; overflow_clr coinciding with a 4th strobe -> overflow=1, dropped_count=1.
REQ-046 Abort: enable dropped after 5 strobes -> FSM IDLE; re-enable plus 8 strobes -> the frame contains only the new 8 samples, in bank 0.
REQ-047 Async reset: assert reset mid-fill while a frame is presented -> all outputs 0 without waiting for a clock edge; a subsequent fill starts at bank 0.
